// File: rtl/kd_tree_pkg.sv
// Shared KD-tree definitions: node configuration word layout, split-dimension limits
// and the loader FSM state encoding.
package kd_tree_pkg;

  localparam int IDX_WIDTH    = 3;
  localparam int MEDIAN_WIDTH = 11;
  localparam int NUM_DIMS     = 5;
  localparam int IDX_LSB      = 0;
  localparam int MEDIAN_LSB   = 11;

  // The whole split field below the median; only the low IDX_WIDTH bits carry the index.
  localparam int SPLIT_FIELD_WIDTH = MEDIAN_LSB - IDX_LSB;

  localparam logic [IDX_WIDTH-1:0] INVALID_IDX = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } loader_state_e;

  // A split field is illegal if the index names a nonexistent dimension or any
  // of the reserved upper bits are set.
  function automatic logic split_field_illegal(input logic [SPLIT_FIELD_WIDTH-1:0] split);
    return (split[IDX_WIDTH-1:0] >= IDX_WIDTH'(NUM_DIMS)) ||
           (split[SPLIT_FIELD_WIDTH-1:IDX_WIDTH] != '0);
  endfunction

endpackage

// File: rtl/node_wen_decoder.sv
// Combinational node-address to one-hot write-enable decoder with a global enable.
module node_wen_decoder #(
  parameter int NUM_NODES  = 63,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  i_en,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [NUM_NODES-1:0]  o_onehot
);

  localparam logic [NUM_NODES-1:0] ONE = NUM_NODES'(1);

  // Addresses at or beyond NUM_NODES shift the bit out, so no node is selected.
  assign o_onehot = i_en ? (ONE << i_addr) : '0;

endmodule

// File: rtl/kd_tree_node_loader.sv
// Streams node configuration words into the KD-tree's internal nodes, word k to node k.
// Optional macro LOADER_IDX_CHECK_EN builds the sticky illegal-split-index detector.
module kd_tree_node_loader
  import kd_tree_pkg::*;
#(
  parameter int NUM_NODES     = 63,
  parameter int ADDR_WIDTH    = 6,
  parameter int STORAGE_WIDTH = 22
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [STORAGE_WIDTH-1:0] in_data,
  output logic [NUM_NODES-1:0]     node_wen,
  output logic [STORAGE_WIDTH-1:0] node_wdata,
  output logic                     busy,
  output logic                     done,
  output logic                     tree_ready,
  output logic                     cfg_error
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_NODES - 1);

  loader_state_e r_state;
  loader_state_e w_next_state;

  logic [ADDR_WIDTH-1:0]    r_count;
  logic [NUM_NODES-1:0]     r_node_wen;
  logic [STORAGE_WIDTH-1:0] r_node_wdata;
  logic                     r_tree_ready;

  logic                 w_in_ready;
  logic                 w_busy;
  logic                 w_done;
  logic                 w_accept;
  logic                 w_start;
  logic [NUM_NODES-1:0] w_onehot;

  // NOTE: reset is sampled on the clock edge, so it belongs inside the clocked branch
  // and every state flop gets an explicit reset value there.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop sees
      // pre-edge values regardless of statement order.
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that left one
    // unassigned would infer a latch.
    w_next_state = r_state;
    w_in_ready   = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next_state = ST_LOAD;
      end
      ST_LOAD: begin
        w_in_ready = 1'b1;
        w_busy     = 1'b1;
        if (in_valid && (r_count == LAST_ADDR)) w_next_state = ST_DONE;
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_accept = in_valid && w_in_ready;
  assign w_start  = start && (r_state == ST_IDLE);

  node_wen_decoder #(
    .NUM_NODES  (NUM_NODES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_wen_decoder (
    .i_en     (w_accept),
    .i_addr   (r_count),
    .o_onehot (w_onehot)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count      <= '0;
      r_node_wen   <= '0;
      r_node_wdata <= '0;
      r_tree_ready <= 1'b0;
    end else begin
      r_node_wen <= w_onehot;
      if (w_accept) begin
        r_node_wdata <= in_data;
        // Saturate at the last node; only a new start rewinds the counter.
        if (r_count != LAST_ADDR) r_count <= r_count + 1'b1;
      end
      if (w_start) begin
        r_count      <= '0;
        r_tree_ready <= 1'b0;
      end else if (r_state == ST_DONE) begin
        r_tree_ready <= 1'b1;
      end
    end
  end

`ifdef LOADER_IDX_CHECK_EN
  logic r_cfg_error;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cfg_error <= 1'b0;
    end else if (w_start) begin
      r_cfg_error <= 1'b0;
    end else if (w_accept && split_field_illegal(in_data[MEDIAN_LSB-1:IDX_LSB])) begin
      r_cfg_error <= 1'b1;
    end
  end

  assign cfg_error = r_cfg_error;
`else
  assign cfg_error = 1'b0;
`endif

  assign in_ready   = w_in_ready;
  assign busy       = w_busy;
  assign done       = w_done;
  assign node_wen   = r_node_wen;
  assign node_wdata = r_node_wdata;
  assign tree_ready = r_tree_ready;

endmodule

// File: doc/kd_tree_node_loader.md
# kd_tree_node_loader

Programs the KD-tree's internal nodes before search begins. Accepts a stream of node configuration words (split dimension index plus median) over a valid/ready handshake and writes word k into node k. For each accepted word it drives the shared write-data bus and a one-hot write enable. It sits between the off-chip/FIFO configuration receiver and the array of internal nodes, and it reports when the whole tree is loaded.

## Interface
Parameters:
- NUM_NODES, 63, number of internal nodes (complete tree of depth 6)
- ADDR_WIDTH, 6, width of node counter; must satisfy 2^ADDR_WIDTH >= NUM_NODES
- STORAGE_WIDTH, 22, node configuration word width

Ports:
- clk  in  1  single clock; everything is sampled on its rising edge
- rst_n  in  1  reset, synchronous and active-low
- start  in  1  one-cycle pulse that begins a full tree load
- in_valid  in  1  upstream word valid
- in_ready  out  1  loader accepts a word this cycle
- in_data  in  STORAGE_WIDTH  [10:0] split index (only [2:0] meaningful, legal 0..4); [21:11] signed 11-bit median
- node_wen  out  NUM_NODES  one-hot write enable, bit k targets node k
- node_wdata  out  STORAGE_WIDTH  registered copy of the accepted word
- busy  out  1  high while in LOAD
- done  out  1  one-cycle pulse when the last node is written
- tree_ready  out  1  level; high after a complete load until the next start or reset
- cfg_error  out  1  sticky illegal-index flag (see Configuration)

## Operation
- States: IDLE, LOAD, DONE.
- IDLE: in_ready=0. start=1 -> LOAD, count<=0, tree_ready<=0, cfg_error<=0.
- LOAD: in_ready=1 (decoded from state only, with no dependence on in_valid). On accept (in_valid && in_ready): node_wdata<=in_data, node_wen<=one-hot(count), count<=count+1. Accepting the word at count==NUM_NODES-1 moves the FSM to DONE. With no accept, node_wen<=0 and node_wdata holds.
- DONE: lasts exactly one cycle. done=1, tree_ready<=1, then IDLE.
- start during LOAD or DONE is ignored. start in IDLE while tree_ready=1 begins a reload and clears tree_ready.
- The counter never wraps past NUM_NODES-1 and is cleared only by start or reset.
- Upstream words presented in IDLE or DONE are not consumed and stay pending upstream.

## Timing
- Reset values: in_ready=0, node_wen=0, node_wdata=0, busy=0, done=0, tree_ready=0, cfg_error=0, state=IDLE, count=0.
- start seen in cycle N -> in_ready=1 in cycle N+1.
- Word accepted in cycle N -> matching node_wen bit and node_wdata valid during cycle N+1; the node captures the word on the edge ending N+1.
- node_wen is high for exactly one cycle per accepted word and never has more than one bit set.
- Throughput is one word per cycle, so a full load takes NUM_NODES+2 cycles from start with continuous in_valid.
- Last word accepted in cycle N -> state DONE and done=1 in N+1 (same cycle as the final node_wen), tree_ready=1 from N+2, in_ready=0 from N+1.
- rst_n=0 mid-load: on the next edge all outputs return to reset values. Partially loaded nodes are reset by their own rst_n.

## Configuration
- LOADER_IDX_CHECK_EN defined: on each accept, if in_data[2:0] > 4 or in_data[10:3] != 0, cfg_error is set in the following cycle and stays set until start or reset. The load continues and the word is still written.
- Undefined: no checking logic is built and cfg_error is tied to 0.

## Structure
- Shared package kd_tree_pkg holds:
  - IDX_WIDTH=3, MEDIAN_WIDTH=11, NUM_DIMS=5
  - field offsets IDX_LSB=0, MEDIAN_LSB=11
  - INVALID_IDX=3'b111
  - the loader state enum
- One sub-module, node_wen_decoder: combinational ADDR_WIDTH -> NUM_NODES one-hot decoder with an enable input. Its output is registered in the loader.

## Test plan
- Reset then start, stream 63 words with data=k in bits [21:11] and idx=k%5 -> node_wen bit k with node_wdata median=k one cycle after each accept; done pulses with word 62's write; tree_ready=1 two cycles after the last accept.
- in_valid toggled 1,0,0,1 during LOAD -> node_wen only in cycles after accepts; count advances by 2; node_wdata holds through the gaps.
- start pulsed at word 10 of a load -> ignored; load completes normally at 63 words.
- rst_n=0 after word 30 -> next cycle node_wen=0, busy=0, tree_ready=0; a new start reloads from node 0.
- With LOADER_IDX_CHECK_EN defined, word 5 has idx=3'b110 -> cfg_error=1 from the cycle after the accept through done; it clears on the next start. With the macro undefined, cfg_error stays 0.
- in_valid=1 held in IDLE before start -> in_ready=0 and no node_wen asserted.
